// File: rtl/dron_pkg.sv
// Shared types and helpers for the quad-motor mixer: FSM states, motor indices,
// duty width and the saturate-to-duty function.
package dron_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARM_WAIT = 2'd1,
        ARMED    = 2'd2
    } state_t;

    localparam int FL       = 0;
    localparam int FR       = 1;
    localparam int RL       = 2;
    localparam int RR       = 3;
    localparam int N_MOTORS = 4;
    localparam int DUTY_W   = 8;

    // Clamp a signed mix sum into the unsigned duty range 0..255.
    function automatic logic [DUTY_W-1:0] sat_duty(input logic signed [9:0] v);
        if (v < 10'sd0)
            return '0;
        else if (v > 10'sd255)
            return '1;
        else
            return v[DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/dron_pwm_timebase.sv
// PWM timebase: prescaler, 8-bit period counter and a one-clk period_start
// pulse marking the clk in which cnt becomes 0.
module dron_pwm_timebase
    import dron_pkg::*;
#(
    parameter int PWM_DIV = 100
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [DUTY_W-1:0] cnt,
    output logic              period_start
);

    localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    logic [PW-1:0] prescaler;
    logic          terminal;

    assign terminal = (prescaler == PW'(PWM_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler    <= '0;
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= 1'b0;
            if (terminal) begin
                prescaler    <= '0;
                cnt          <= cnt + 1'b1;
                period_start <= (cnt == '1);
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dron_motor_mixer.sv
// Quad-motor mixer: stick offsets + throttle -> four PWM duties, gated by an
// arming FSM. Define DRON_SOFT_START_EN to rate-limit duty changes per period.
module dron_motor_mixer
    import dron_pkg::*;
#(
    parameter int PWM_DIV   = 100,
    parameter int CENTER    = 64,
    parameter int DEADZONE  = 8,
    parameter int RAMP_STEP = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [11:0]         value_x,
    input  logic [11:0]         value_y,
    input  logic [7:0]          throttle,
    input  logic                arm,
    output logic [N_MOTORS-1:0] pwm,
    output logic                armed,
    output logic                period_start
);

    localparam logic signed [7:0] CTR = 8'(CENTER);
    localparam logic signed [7:0] DZ  = 8'(DEADZONE);

    logic [DUTY_W-1:0] cnt;
    logic [DUTY_W-1:0] target    [N_MOTORS];
    logic [DUTY_W-1:0] duty      [N_MOTORS];
    logic [DUTY_W-1:0] next_duty [N_MOTORS];
    logic signed [7:0] off_x, off_y, roll, pitch;
    logic signed [9:0] t_s, p_s, r_s;
    logic [7:0]        thr_q;
    state_t            state;
    logic              unused_hi_bits;

    dron_pwm_timebase #(.PWM_DIV(PWM_DIV)) u_timebase (
        .clk          (clk),
        .reset_n      (reset_n),
        .cnt          (cnt),
        .period_start (period_start)
    );

    function automatic logic signed [7:0] dead_zone(input logic signed [7:0] v);
        if (v <= DZ && v >= -DZ)
            return 8'sd0;
        else
            return v;
    endfunction

    assign unused_hi_bits = ^{value_x[11:7], value_y[11:7]};
    assign off_x = $signed({1'b0, value_x[6:0]}) - CTR;
    assign off_y = $signed({1'b0, value_y[6:0]}) - CTR;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            roll  <= '0;
            pitch <= '0;
            thr_q <= '0;
        end else begin
            roll  <= dead_zone(off_x);
            pitch <= dead_zone(off_y);
            thr_q <= throttle;
        end
    end

    assign t_s = $signed({2'b00, thr_q});
    assign p_s = $signed({{2{pitch[7]}}, pitch});
    assign r_s = $signed({{2{roll[7]}}, roll});

    // NOTE: the small target/duty arrays are plain flops, so they take the async reset too.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_MOTORS; i++) target[i] <= '0;
        end else begin
            target[FL] <= sat_duty(t_s + p_s + r_s);
            target[FR] <= sat_duty(t_s + p_s - r_s);
            target[RL] <= sat_duty(t_s - p_s + r_s);
            target[RR] <= sat_duty(t_s - p_s - r_s);
        end
    end

`ifdef DRON_SOFT_START_EN
    localparam logic [DUTY_W-1:0] STEP = DUTY_W'(RAMP_STEP);

    always_comb begin
        for (int i = 0; i < N_MOTORS; i++) begin
            next_duty[i] = duty[i];
            if (target[i] > duty[i])
                next_duty[i] = (target[i] - duty[i] > STEP) ? duty[i] + STEP : target[i];
            else if (target[i] < duty[i])
                next_duty[i] = (duty[i] - target[i] > STEP) ? duty[i] - STEP : target[i];
        end
    end
`else
    localparam int unused_ramp_step = RAMP_STEP;

    always_comb begin
        for (int i = 0; i < N_MOTORS; i++) next_duty[i] = target[i];
    end
`endif

    // Arming FSM; duties only move on period boundaries and clear on any disarm.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= DISARMED;
            armed <= 1'b0;
            for (int i = 0; i < N_MOTORS; i++) duty[i] <= '0;
        end else begin
            case (state)
                DISARMED: begin
                    if (arm && throttle == 8'd0) state <= ARM_WAIT;
                end
                ARM_WAIT, ARMED: begin
                    if (!arm) begin
                        state <= DISARMED;
                        armed <= 1'b0;
                        for (int i = 0; i < N_MOTORS; i++) duty[i] <= '0;
                    end else if (period_start) begin
                        state <= ARMED;
                        armed <= 1'b1;
                        for (int i = 0; i < N_MOTORS; i++) duty[i] <= next_duty[i];
                    end
                end
                default: begin
                    state <= DISARMED;
                    armed <= 1'b0;
                    for (int i = 0; i < N_MOTORS; i++) duty[i] <= '0;
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < N_MOTORS; i++) pwm[i] = armed && (cnt < duty[i]);
    end

endmodule

// File: tb/tb_dron_motor_mixer.sv
// Self-checking bench for dron_motor_mixer: measures PWM high time per period
// against a plain-arithmetic mixing model, plus arming/disarm/reset behaviour.
module tb_dron_motor_mixer;

    localparam int PWM_DIV = 2;
    localparam int PERIOD  = 256 * PWM_DIV;
    localparam int BOUND   = PERIOD + 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] value_x, value_y;
    logic [7:0]  throttle;
    logic        arm;
    logic [3:0]  pwm;
    logic        armed, period_start;

    int n_checks = 0;
    int n_fail   = 0;
    int hi_cnt[4];
    int cyc = 0;
    int t0, a_hi, p_hi;

    dron_motor_mixer #(
        .PWM_DIV(PWM_DIV), .CENTER(64), .DEADZONE(8), .RAMP_STEP(4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .value_x      (value_x),
        .value_y      (value_y),
        .throttle     (throttle),
        .arm          (arm),
        .pwm          (pwm),
        .armed        (armed),
        .period_start (period_start)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: stick offset from centre with deadzone.
    function automatic int ref_off(input logic [11:0] v);
        int o;
        o = int'(v[6:0]) - 64;
        return (o <= 8 && o >= -8) ? 0 : o;
    endfunction

    // Reference: mixed duty for motor m (FL, FR, RL, RR) clamped to 0..255.
    function automatic int ref_duty(input int t, input int p, input int r, input int m);
        int s;
        case (m)
            0:       s = t + p + r;
            1:       s = t + p - r;
            2:       s = t - p + r;
            default: s = t - p - r;
        endcase
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    task automatic wait_ps();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < BOUND);
        if (!period_start) check("period_start_timeout", 0, 1);
    endtask

    task automatic wait_armed(input string tag);
        int n = 0;
        while (!armed && n < 3 * PERIOD) begin
            @(negedge clk);
            n++;
        end
        check(tag, int'(armed), 1);
    endtask

    // Count high samples per motor over one period starting at the current negedge.
    task automatic measure(input int skip);
        hi_cnt = '{default: 0};
        for (int i = 0; i < PERIOD; i++) begin
            if (i >= skip)
                for (int m = 0; m < 4; m++) hi_cnt[m] += int'(pwm[m]);
            @(negedge clk);
        end
    endtask

    task automatic observe(input int n, output int armed_hi, output int pwm_hi);
        armed_hi = 0;
        pwm_hi   = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            armed_hi += int'(armed);
            pwm_hi   += int'(pwm != 4'b0000);
        end
    endtask

    task automatic run_vec(input logic [11:0] x, input logic [11:0] y, input logic [7:0] t,
                           input string tag);
        int p, r;
        value_x  = x;
        value_y  = y;
        throttle = t;
        repeat (3) wait_ps();
        measure(0);
        p = ref_off(y);
        r = ref_off(x);
        for (int m = 0; m < 4; m++)
            check($sformatf("%s_m%0d", tag, m), hi_cnt[m], ref_duty(int'(t), p, r, m) * PWM_DIV);
    endtask

    initial begin
        value_x  = 12'd64;
        value_y  = 12'd64;
        throttle = 8'd0;
        arm      = 1'b0;
        reset_n  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_pwm", int'(pwm), 0);
        check("reset_armed", int'(armed), 0);
        check("reset_period_start", int'(period_start), 0);
        reset_n = 1'b1;

        observe(2 * PERIOD, a_hi, p_hi);
        check("disarmed_armed_hi", a_hi, 0);
        check("disarmed_pwm_hi", p_hi, 0);
        wait_ps();
        t0 = cyc;
        wait_ps();
        check("ps_spacing_1", cyc - t0, PERIOD);
        t0 = cyc;
        wait_ps();
        check("ps_spacing_2", cyc - t0, PERIOD);

        arm = 1'b1;
        repeat (10) @(negedge clk);
        check("arm_wait_not_armed", int'(armed), 0);
        wait_ps();
        check("armed_low_at_ps", int'(armed), 0);
        @(negedge clk);
        check("armed_after_ps", int'(armed), 1);

`ifndef DRON_SOFT_START_EN
        run_vec(12'd64, 12'd64, 8'd128, "t128");
        run_vec(12'd64, 12'd127, 8'd128, "pitch63");
        run_vec(12'd127, 12'd127, 8'd240, "sat_high");
        run_vec(12'd0, 12'd0, 8'd10, "sat_low");
        run_vec(12'd70, 12'd57, 8'd128, "deadzone_in");
        run_vec(12'h848, 12'd64, 8'd100, "dz_edge8");
        run_vec(12'd73, 12'd64, 8'd100, "dz_edge9");
        for (int k = 0; k < 7; k++)
            run_vec(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                    8'($urandom_range(0, 255)), $sformatf("rnd%0d", k));
`else
        throttle = 8'd200;
        repeat (4) @(negedge clk);
        wait_ps();
        for (int k = 1; k <= 55; k++) begin
            int d;
            measure(1);
            d = (4 * k > 200) ? 200 : 4 * k;
            if (k == 1 || k == 2 || k == 25 || k == 49 || k == 50 || k == 55)
                check($sformatf("ramp_k%0d", k), hi_cnt[0], d * PWM_DIV - 1);
        end
`endif

        // Drop arm mid-period while running at T=200.
        value_x  = 12'd64;
        value_y  = 12'd64;
        throttle = 8'd200;
        repeat (3) wait_ps();
        repeat (50) @(negedge clk);
        check("run_pwm_all_high", int'(pwm), 15);
        check("run_armed", int'(armed), 1);
        arm = 1'b0;
        @(negedge clk);
        check("disarm_armed", int'(armed), 0);
        check("disarm_pwm", int'(pwm), 0);

        // Disarm in the same clk as period_start.
        throttle = 8'd0;
        arm      = 1'b1;
        wait_armed("rearm");
        throttle = 8'd200;
        repeat (2) wait_ps();
        wait_ps();
        arm = 1'b0;
        @(negedge clk);
        check("ps_disarm_armed", int'(armed), 0);
        check("ps_disarm_pwm", int'(pwm), 0);
        observe(100, a_hi, p_hi);
        check("ps_disarm_pwm_hold", p_hi, 0);

        // Arm request with throttle above zero must be refused.
        throttle = 8'd50;
        arm      = 1'b1;
        observe(2 * PERIOD, a_hi, p_hi);
        check("arm_throttle50_armed_hi", a_hi, 0);
        check("arm_throttle50_pwm_hi", p_hi, 0);

        // Asynchronous reset mid-period, then arming needs throttle==0 again.
        arm      = 1'b0;
        @(negedge clk);
        throttle = 8'd0;
        arm      = 1'b1;
        wait_armed("arm_before_reset");
        throttle = 8'd200;
        wait_ps();
        repeat (60) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset_armed", int'(armed), 0);
        check("midreset_pwm", int'(pwm), 0);
        check("midreset_period_start", int'(period_start), 0);
        @(negedge clk);
        reset_n = 1'b1;
        observe(2 * PERIOD, a_hi, p_hi);
        check("post_reset_throttle200_armed_hi", a_hi, 0);
        throttle = 8'd0;
        wait_armed("post_reset_rearm");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
